pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. Decides each cycle whether PC, IF/ID,
//   ID/EX, EX/MEM and MEM/WB advance, stall or take a bubble. Sources: load-use hazards,
//   taken branches/jumps, instruction-memory wait, data-memory wait and multi-cycle mul/div.
//   Also keeps saturating stall/flush performance counters and a sticky wait-timeout flag.
// PARAMETERS
//   REG_W     5    register-index width
//   CNT_W     32   width of the perf counters
//   MAX_WAIT  255  wait cycles (DMEM_WAIT or MULDIV_WAIT) before timeout_err sets
// PORTS
//   clk            in   1      clock; all state updates on posedge
//   rst            in   1      reset, asynchronous, active-high
//   id_rs1,id_rs2  in   REG_W  source registers of the instruction in ID
//   id_use_rs1/2   in   1      instruction in ID reads rs1 / rs2
//   ex_memread     in   1      instruction in EX is a load
//   ex_rd          in   REG_W  destination register of the instruction in EX
//   ex_br_taken    in   1      branch/jump in EX resolved taken (PC redirects this cycle)
//   ex_is_muldiv   in   1      instruction in EX is mul/div
//   muldiv_done    in   1      mul/div unit result valid
//   im_ready       in   1      instruction memory returns valid data this cycle
//   dm_req         in   1      instruction in MEM accesses data memory
//   dm_ready       in   1      data memory completes the access this cycle
//   pc_stall       out  1      hold PC
//   if_stall       out  1      IF/ID holds its contents
//   if_flush       out  1      IF/ID loads a bubble (flush has priority over stall downstream)
//   id_flush       out  1      ID/EX loads a bubble
//   ex_stall       out  1      ID/EX holds its contents
//   mem_stall      out  1      EX/MEM and MEM/WB hold their contents
//   muldiv_start   out  1      1-cycle start pulse to the mul/div unit
//   timeout_err    out  1      sticky wait-timeout flag
//   stall_cycles   out  CNT_W  cycles with pc_stall=1, saturating
//   flush_count    out  CNT_W  taken-branch flushes, saturating
// BEHAVIOUR
//   - Reset: state=RUN, wait_cnt=0, counters=0, timeout_err=0; while rst=1 all 1-bit outputs 0.
//   - Control outputs are combinational (same cycle) from state + inputs; state/counters registered.
//   - ld_use = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//   - States: RUN, DMEM_WAIT, MULDIV_WAIT. Priority in RUN, highest first:
//     1 dm_req & !dm_ready: pc/if/ex/mem_stall=1; -> DMEM_WAIT. Lower sources ignored this cycle.
//     2 ex_is_muldiv & !muldiv_done: pc/if/ex_stall=1, muldiv_start=1, mem_stall=0; -> MULDIV_WAIT.
//     3 ex_br_taken: if_flush=1, id_flush=1, pc_stall=0; flush_count+1. Overrides ld_use, im_ready=0.
//     4 ld_use: pc_stall=1, if_stall=1, id_flush=1 (single bubble; load leaves EX next edge).
//     5 !im_ready: pc_stall=1, if_flush=1.
//     6 else all control outputs 0.
//   - ex_is_muldiv & muldiv_done in RUN: no stall; muldiv_start=1 for that cycle only.
//   - DMEM_WAIT: pc/if/ex/mem_stall=1 while !dm_ready. dm_ready=1: all stalls 0 that cycle, -> RUN.
//   - MULDIV_WAIT: pc/if/ex_stall=1 while !muldiv_done; muldiv_start=0. muldiv_done=1: release
//     stalls that cycle, -> RUN. Downstream bubble on ID/EX not needed (EX held).
//   - Branch/ld_use/imem sources are not evaluated in either wait state.
//   - wait_cnt: cleared on entry to a wait state, +1 each wait cycle; when wait_cnt reaches
//     MAX_WAIT, timeout_err sets and stays 1 until rst; state unchanged (keeps waiting).
//   - stall_cycles += 1 every cycle pc_stall=1; flush_count += 1 per case-3 cycle; both hold at
//     all-ones. Counters never wrap.
//   - rst asserted mid-wait: immediate return to RUN, counters and flag cleared.
// TESTING
//   T1 ex_memread=1,ex_rd=5,id_rs1=5,id_use_rs1=1 -> 1 cycle pc_stall=if_stall=id_flush=1; then 0.
//   T2 same as T1 with ex_rd=0 -> no stall. Same with ex_br_taken=1 -> if_flush=id_flush=1,
//      pc_stall=0, flush_count=1.
//   T3 dm_req=1,dm_ready=0 for 3 cycles then 1 -> pc/if/ex/mem_stall=1 for 3 cycles, 0 on 4th;
//      stall_cycles=3; concurrent ex_br_taken ignored during wait.
//   T4 ex_is_muldiv=1, muldiv_done after 4 cycles -> muldiv_start pulse 1 cycle, pc/if/ex_stall=1
//      4 cycles, mem_stall=0 throughout.
//   T5 MAX_WAIT=4, dm_ready held 0 -> timeout_err=1 after 4 wait cycles, stays 1; rst clears all.
//   T6 !im_ready with no other source -> pc_stall=1, if_flush=1; force counters to all-ones -> hold.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with saturating
// stall/flush performance counters and a sticky wait-timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic             ex_is_muldiv,
  input  logic             muldiv_done,
  input  logic             im_ready,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_stall,
  output logic             if_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             muldiv_start,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {StRun, StDmemWait, StMuldivWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic             timeout_q, timeout_set;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             flush_evt;
  logic             ld_use;

  logic pc_stall_c, if_stall_c, if_flush_c, id_flush_c, ex_stall_c, mem_stall_c, muldiv_start_c;

  assign ld_use = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  assign wait_inc = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_set    = 1'b0;
    flush_evt      = 1'b0;
    pc_stall_c     = 1'b0;
    if_stall_c     = 1'b0;
    if_flush_c     = 1'b0;
    id_flush_c     = 1'b0;
    ex_stall_c     = 1'b0;
    mem_stall_c    = 1'b0;
    muldiv_start_c = 1'b0;

    unique case (state_q)
      StRun: begin
        if (dm_req && !dm_ready) begin
          pc_stall_c  = 1'b1;
          if_stall_c  = 1'b1;
          ex_stall_c  = 1'b1;
          mem_stall_c = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StDmemWait;
        end else if (ex_is_muldiv && !muldiv_done) begin
          pc_stall_c     = 1'b1;
          if_stall_c     = 1'b1;
          ex_stall_c     = 1'b1;
          muldiv_start_c = 1'b1;
          wait_cnt_d     = '0;
          state_d        = StMuldivWait;
        end else begin
          // A mul/div whose result is already valid only needs the start pulse.
          muldiv_start_c = ex_is_muldiv;
          if (ex_br_taken) begin
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
            flush_evt  = 1'b1;
          end else if (ld_use) begin
            pc_stall_c = 1'b1;
            if_stall_c = 1'b1;
            id_flush_c = 1'b1;
          end else if (!im_ready) begin
            pc_stall_c = 1'b1;
            if_flush_c = 1'b1;
          end
        end
      end
      StDmemWait: begin
        if (!dm_ready) begin
          pc_stall_c  = 1'b1;
          if_stall_c  = 1'b1;
          ex_stall_c  = 1'b1;
          mem_stall_c = 1'b1;
          wait_cnt_d  = wait_inc;
          timeout_set = (wait_inc == WaitMax);
        end else begin
          state_d = StRun;
        end
      end
      StMuldivWait: begin
        if (!muldiv_done) begin
          pc_stall_c  = 1'b1;
          if_stall_c  = 1'b1;
          ex_stall_c  = 1'b1;
          wait_cnt_d  = wait_inc;
          timeout_set = (wait_inc == WaitMax);
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (pc_stall_c && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush_evt && (flush_count_q != '1))   flush_count_d  = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_q | timeout_set;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Control outputs are forced low for as long as reset is held.
  assign pc_stall     = pc_stall_c     & ~rst;
  assign if_stall     = if_stall_c     & ~rst;
  assign if_flush     = if_flush_c     & ~rst;
  assign id_flush     = id_flush_c     & ~rst;
  assign ex_stall     = ex_stall_c     & ~rst;
  assign mem_stall    = mem_stall_c    & ~rst;
  assign muldiv_start = muldiv_start_c & ~rst;
  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
